// File: rtl/gpio_frame_ctrl.sv
// Host command decoder and frame-buffer controller bridging gpi0/gpo0 to pixel RAM and conv core.
// Optional FRAME_CTRL_CMD_COUNT_EN adds an accepted-command counter reported by IS_FRAME_READY.
module gpio_frame_ctrl #(
  parameter int unsigned NB_GPIOS     = 32,
  parameter int unsigned NB_COM       = 7,
  parameter int unsigned NB_DATA      = 24,
  parameter int unsigned RAM_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH    = 128,
  parameter int unsigned IMAGE_WIDTH  = 10,
  parameter int unsigned IMAGE_HEIGHT = 10,
  localparam int unsigned NB_ADDR     = $clog2(RAM_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NB_GPIOS-1:0]  gpi0,
  output logic [NB_GPIOS-1:0]  gpo0,
  output logic                 wr_en,
  output logic [NB_ADDR-1:0]   wr_addr,
  output logic [RAM_WIDTH-1:0] wr_data,
  output logic [NB_ADDR-1:0]   rd_addr,
  input  logic [RAM_WIDTH-1:0] rd_data,
  output logic [1:0]           kernel_sel,
  output logic                 conv_start,
  input  logic                 conv_done
);

  localparam int unsigned FRAME_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned WIN_W      = NB_GPIOS - RAM_WIDTH;

  localparam logic [NB_COM-1:0] CmdKernelSel   = NB_COM'(0);
  localparam logic [NB_COM-1:0] CmdLoadFrame   = NB_COM'(1);
  localparam logic [NB_COM-1:0] CmdEndFrame    = NB_COM'(2);
  localparam logic [NB_COM-1:0] CmdIsFrameRdy  = NB_COM'(3);
  localparam logic [NB_COM-1:0] CmdGetFrame    = NB_COM'(4);
  localparam logic [NB_ADDR-1:0] LastAddr      = NB_ADDR'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StExec, StRdWait, StRdLatch} state_e;

  state_e state_q, state_d;

  logic [NB_GPIOS-1:0]  gpi_q;
  logic                 strobe_prev_q;
  logic [NB_GPIOS-1:0]  gpo_q, gpo_d;
  logic                 wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0]   wr_addr_q, wr_addr_d;
  logic [RAM_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NB_ADDR-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]           ksel_q, ksel_d;
  logic                 conv_start_q, conv_start_d;
  logic                 start_pend_q, start_pend_d;
  logic [NB_ADDR-1:0]   wptr_q, wptr_d;
  logic [NB_ADDR-1:0]   rptr_q, rptr_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic                 ready_q, ready_d;
  logic                 overrun_q, overrun_d;
  logic                 get_q, get_d;

  logic                 cmd_edge;
  logic                 accept;
  logic [NB_COM-1:0]    cmd;
  logic [NB_DATA-1:0]   data;
  logic                 unused_data;

  assign cmd         = gpi_q[NB_GPIOS-2 -: NB_COM];
  assign data        = gpi_q[NB_DATA-1:0];
  assign cmd_edge    = gpi_q[NB_GPIOS-1] & ~strobe_prev_q;
  assign accept      = cmd_edge && (state_q == StIdle);
  assign unused_data = ^data[NB_DATA-1:RAM_WIDTH];

`ifdef FRAME_CTRL_CMD_COUNT_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;

  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    if (accept) cmd_cnt_d = cmd_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cmd_cnt_q <= '0;
    else       cmd_cnt_q <= cmd_cnt_d;
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cmd_edge) state_d = StExec;
      StExec:    state_d = get_q ? StRdWait : StIdle;
      StRdWait:  state_d = StRdLatch;
      StRdLatch: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    gpo_d        = gpo_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    ksel_d       = ksel_q;
    conv_start_d = 1'b0;
    start_pend_d = start_pend_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    win_d        = win_q;
    overrun_d    = overrun_q;
    get_d        = get_q;

    if (cmd_edge && (state_q != StIdle)) overrun_d = 1'b1;

    if (accept) begin
      get_d = (cmd == CmdGetFrame);
      case (cmd)
        CmdKernelSel: begin
          ksel_d = data[1:0];
          gpo_d  = NB_GPIOS'(data[1:0]);
        end
        CmdLoadFrame: begin
          wr_en_d   = 1'b1;
          wr_addr_d = wptr_q;
          wr_data_d = data[RAM_WIDTH-1:0];
          gpo_d     = NB_GPIOS'(data[RAM_WIDTH-1:0]);
          if (wptr_q == LastAddr) begin
            wptr_d       = '0;
            start_pend_d = 1'b1;
          end else begin
            wptr_d = wptr_q + NB_ADDR'(1);
          end
        end
        CmdEndFrame: begin
          wptr_d       = '0;
          rptr_d       = '0;
          start_pend_d = 1'b1;
          gpo_d        = '0;
        end
        CmdIsFrameRdy: begin
`ifdef FRAME_CTRL_CMD_COUNT_EN
          gpo_d = NB_GPIOS'({cmd_cnt_q, 6'b0, overrun_q, ready_q});
`else
          gpo_d = NB_GPIOS'({overrun_q, ready_q});
`endif
          overrun_d = 1'b0;
        end
        CmdGetFrame: begin
          rd_addr_d = rptr_q;
          rptr_d    = (rptr_q == LastAddr) ? '0 : rptr_q + NB_ADDR'(1);
        end
        default: gpo_d = NB_GPIOS'({1'b1, cmd, 24'hBAD0AD});
      endcase
    end

    if (state_q == StExec) begin
      conv_start_d = start_pend_q;
      start_pend_d = 1'b0;
    end

    // rd_data is valid here, one cycle after rd_addr was presented
    if (state_q == StRdWait) begin
      win_d = {win_q[WIN_W-RAM_WIDTH-1:0], rd_data};
      gpo_d = {win_q, rd_data};
    end

    ready_d = ready_q;
    if (conv_start_d)   ready_d = 1'b0;
    else if (conv_done) ready_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpi_q         <= '0;
      strobe_prev_q <= 1'b0;
      gpo_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      ksel_q        <= '0;
      conv_start_q  <= 1'b0;
      start_pend_q  <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      win_q         <= '0;
      ready_q       <= 1'b0;
      overrun_q     <= 1'b0;
      get_q         <= 1'b0;
    end else begin
      gpi_q         <= gpi0;
      strobe_prev_q <= gpi_q[NB_GPIOS-1];
      gpo_q         <= gpo_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_addr_q     <= rd_addr_d;
      ksel_q        <= ksel_d;
      conv_start_q  <= conv_start_d;
      start_pend_q  <= start_pend_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      win_q         <= win_d;
      ready_q       <= ready_d;
      overrun_q     <= overrun_d;
      get_q         <= get_d;
    end
  end

  assign gpo0       = gpo_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_addr    = rd_addr_q;
  assign kernel_sel = ksel_q;
  assign conv_start = conv_start_q;

endmodule
